// File: rtl/elevator_pkg.sv
// Shared constants for the elevator front end and controller: sizes, timing
// defaults and state encodings.
package elevator_pkg;

    localparam int NUM_FLOORS = 4;
    localparam int FLOOR_W    = 2;
    localparam int COUNT_W    = 3;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 8;
    localparam int DEFAULT_REISSUE_CYCLES  = 64;

    // Per-button debounce FSM.
    localparam logic [1:0] DB_IDLE      = 2'd0;
    localparam logic [1:0] DB_ARMING    = 2'd1;
    localparam logic [1:0] DB_PRESSED   = 2'd2;
    localparam logic [1:0] DB_RELEASING = 2'd3;

    // Elevator controller FSM.
    localparam logic [1:0] CTRL_IDLE      = 2'd0;
    localparam logic [1:0] CTRL_MOVE_UP   = 2'd1;
    localparam logic [1:0] CTRL_MOVE_DOWN = 2'd2;
    localparam logic [1:0] CTRL_DOOR_OPEN = 2'd3;

    function automatic logic [COUNT_W-1:0] popcount(input logic [NUM_FLOORS-1:0] v);
        logic [COUNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            n = n + {{(COUNT_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/elevator_call_panel_debounce.sv
// One call button: 2-flop synchroniser followed by a debounce FSM that emits
// a single press pulse per accepted press, however long the button is held.
module call_debounce
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_meta;
    logic             sync_btn;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            sync_btn  <= 1'b0;
            state     <= DB_IDLE;
            cnt       <= '0;
            press     <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync_btn  <= sync_meta;
            press     <= 1'b0;
            // The sample that leaves IDLE/PRESSED is the first of the run, so cnt starts at 1.
            case (state)
                DB_IDLE: begin
                    if (sync_btn) begin
                        state <= DB_ARMING;
                        cnt   <= CNT_ONE;
                    end
                end
                DB_ARMING: begin
                    if (!sync_btn) begin
                        state <= DB_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= DB_PRESSED;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DB_PRESSED: begin
                    if (!sync_btn) begin
                        state <= DB_RELEASING;
                        cnt   <= CNT_ONE;
                    end
                end
                DB_RELEASING: begin
                    if (sync_btn) begin
                        state <= DB_PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state <= DB_IDLE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= DB_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/elevator_call_panel.sv
// Call panel: debounced buttons become lit call lamps and one-cycle req pulses;
// lamps clear when the controller opens its door at that floor.
module elevator_call_panel
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REISSUE_CYCLES  = DEFAULT_REISSUE_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic                  door,
    output logic [NUM_FLOORS-1:0] req,
    output logic [NUM_FLOORS-1:0] call_lamp,
    output logic [NUM_FLOORS-1:0] served,
    output logic [COUNT_W-1:0]    pending_count
);

    localparam int TMR_W = (REISSUE_CYCLES > 2) ? $clog2(REISSUE_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REISSUE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    logic [NUM_FLOORS-1:0] press;
    logic [31:0]           floor_idx;
    logic                  floor_valid;
    logic [NUM_FLOORS-1:0] floor_onehot;
    logic [NUM_FLOORS-1:0] door_here;
    logic [NUM_FLOORS-1:0] serve_hit;
    logic [NUM_FLOORS-1:0] new_call;
    logic [NUM_FLOORS-1:0] lamp_next;
    logic [TMR_W-1:0]      timer;
    logic                  timer_last;
    logic                  timer_clear;
    logic                  reissue;

    for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_floor
        call_debounce #(
            .DEBOUNCE (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .btn     (btn[f]),
            .press   (press[f])
        );
    end

    assign floor_idx   = 32'(floor);
    assign floor_valid = (floor_idx < 32'(NUM_FLOORS));

    always_comb begin
        floor_onehot = '0;
        if (floor_valid) begin
            floor_onehot[floor] = 1'b1;
        end
    end

    // A press at the floor whose door is open is already served, so it never lights.
    assign door_here = door ? floor_onehot : '0;
    assign serve_hit = door_here & call_lamp;
    assign new_call  = press & ~call_lamp & ~door_here;
    assign lamp_next = (call_lamp | new_call) & ~serve_hit;

    assign timer_last  = (timer == TMR_LAST);
    assign timer_clear = (call_lamp == '0) || (|serve_hit) || (|new_call);
    assign reissue     = !timer_clear && timer_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req           <= '0;
            call_lamp     <= '0;
            served        <= '0;
            pending_count <= '0;
            timer         <= '0;
        end else begin
            req           <= new_call | (reissue ? call_lamp : '0);
            call_lamp     <= lamp_next;
            served        <= serve_hit;
            pending_count <= popcount(call_lamp);
            if (timer_clear || timer_last) begin
                timer <= '0;
            end else begin
                timer <= timer + TMR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed bench for the call panel: a per-floor behavioural model checked
// every cycle, plus literal expectations at the key moments of each scenario.
module tb_elevator_call_panel;
    import elevator_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic [1:0] floor = 2'd0;
    logic       door = 1'b0;
    logic [3:0] req;
    logic [3:0] call_lamp;
    logic [3:0] served;
    logic [2:0] pending_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    elevator_call_panel dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn           (btn),
        .floor         (floor),
        .door          (door),
        .req           (req),
        .call_lamp     (call_lamp),
        .served        (served),
        .pending_count (pending_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: a button is "held" once 8 consecutive synchronised samples disagree
    // with the current held level; the sync chain is two cycles of delay.
    bit       m_s1 [4];
    bit       m_s2 [4];
    bit       m_held [4];
    int       m_run [4];
    bit       m_press [4];
    bit [3:0] m_lamp = 0;
    bit [3:0] m_req = 0;
    bit [3:0] m_served = 0;
    int       m_pc = 0;
    int       m_idle = 0;

    always @(posedge clk or negedge reset_n) begin : model
        bit [3:0] fresh;
        bit [3:0] hit;
        bit [3:0] lamp_old;
        int fl;
        if (!reset_n) begin
            for (int f = 0; f < 4; f++) begin
                m_s1[f] = 0; m_s2[f] = 0; m_held[f] = 0; m_run[f] = 0; m_press[f] = 0;
            end
            m_lamp = 0; m_req = 0; m_served = 0; m_pc = 0; m_idle = 0;
        end else begin
            fl = int'(floor);
            lamp_old = m_lamp;
            hit = 0;
            if (door && fl < 4 && lamp_old[fl]) hit[fl] = 1;
            fresh = 0;
            for (int f = 0; f < 4; f++) begin
                if (m_press[f] && !lamp_old[f] && !(door && fl == f)) fresh[f] = 1;
            end
            m_pc = $countones(lamp_old);
            m_served = hit;
            m_req = fresh;
            if (lamp_old == 0 || hit != 0 || fresh != 0) begin
                m_idle = 0;
            end else if (m_idle == 63) begin
                m_req = lamp_old;
                m_idle = 0;
            end else begin
                m_idle++;
            end
            m_lamp = (lamp_old | fresh) & ~hit;
            for (int f = 0; f < 4; f++) begin
                m_press[f] = 0;
                if (m_s2[f] != m_held[f]) begin
                    m_run[f]++;
                    if (m_run[f] == 8) begin
                        m_held[f] = m_s2[f];
                        m_run[f] = 0;
                        m_press[f] = m_s2[f];
                    end
                end else begin
                    m_run[f] = 0;
                end
                m_s2[f] = m_s1[f];
                m_s1[f] = btn[f];
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_req", req, m_req);
        chk("cyc_lamp", call_lamp, m_lamp);
        chk("cyc_served", served, m_served);
        chk("cyc_count", pending_count, m_pc);
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int first_seen;
        int pulses;
        int early;
        int gap;

        #1;
        chk("reset_req", req, 0);
        chk("reset_lamp", call_lamp, 0);
        chk("reset_served", served, 0);
        chk("reset_count", pending_count, 0);
        step(2);
        reset_n = 1'b1;
        step(2);

        // Clean press on floor 2.
        btn[2] = 1'b1;
        step(10);
        chk("press_early", req, 0);
        step(1);
        chk("press_req", req, 4'b0100);
        chk("press_lamp", call_lamp, 4'b0100);
        step(1);
        chk("press_req_once", req, 0);
        chk("press_count", pending_count, 1);
        step(8);
        btn[2] = 1'b0;
        step(12);

        // Bouncing floor-1 button, then a clean hold.
        early = 0;
        for (int seg = 0; seg < 10; seg++) begin
            btn[1] = (seg % 2 == 0);
            for (int k = 0; k < 3; k++) begin
                step(1);
                if (req[1]) early++;
            end
        end
        chk("bounce_no_req", early, 0);
        btn[1] = 1'b1;
        first_seen = -1;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (req[1]) begin
                pulses++;
                if (first_seen < 0) first_seen = k;
            end
        end
        chk("bounce_first", first_seen, 11);
        chk("bounce_pulses", pulses, 1);
        btn[1] = 1'b0;
        step(12);

        // Build lamps 1010, then serve floor 3.
        floor = 2'd2; door = 1'b1;
        step(1);
        chk("svc2_lamp", call_lamp, 4'b0010);
        chk("svc2_served", served, 4'b0100);
        door = 1'b0;
        step(2);
        btn[3] = 1'b1;
        step(11);
        chk("press3_lamp", call_lamp, 4'b1010);
        btn[3] = 1'b0;
        step(12);
        floor = 2'd3; door = 1'b1;
        step(1);
        chk("svc_lamp", call_lamp, 4'b0010);
        chk("svc_served", served, 4'b1000);
        chk("svc_count_before", pending_count, 2);
        door = 1'b0;
        step(1);
        chk("svc_served_once", served, 0);
        chk("svc_count_after", pending_count, 1);

        // Press at the floor whose door is open.
        floor = 2'd0; door = 1'b1; btn[0] = 1'b1;
        early = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (req[0] || call_lamp[0] || served[0]) early++;
        end
        chk("door_here_ignored", early, 0);
        btn[0] = 1'b0;
        step(12);
        door = 1'b0;

        // Reissue: clear floor 1, light floor 3 alone, watch re-pulses.
        floor = 2'd1; door = 1'b1;
        step(1);
        door = 1'b0; floor = 2'd0;
        step(2);
        chk("reissue_lamps_clear", call_lamp, 0);
        btn[3] = 1'b1;
        first_seen = -1;
        for (int k = 1; k <= 20 && first_seen < 0; k++) begin
            step(1);
            if (req[3]) first_seen = k;
        end
        chk("reissue_new_call", first_seen, 11);
        btn[3] = 1'b0;
        for (int r = 0; r < 2; r++) begin
            gap = -1;
            for (int k = 1; k <= 100 && gap < 0; k++) begin
                step(1);
                if (req[3]) gap = k;
            end
            chk("reissue_gap", gap, 64);
        end

        // Async reset with lamps 0110 and a debounce in progress.
        floor = 2'd3; door = 1'b1;
        step(1);
        door = 1'b0;
        btn[1] = 1'b1; btn[2] = 1'b1;
        step(11);
        chk("pre_reset_lamp", call_lamp, 4'b0110);
        btn[1] = 1'b0; btn[2] = 1'b0;
        step(12);
        btn[0] = 1'b1;
        step(4);
        #2 reset_n = 1'b0;
        #1;
        chk("async_req", req, 0);
        chk("async_lamp", call_lamp, 0);
        chk("async_served", served, 0);
        chk("async_count", pending_count, 0);
        step(3);
        reset_n = 1'b1;
        step(10);
        chk("held_early", req, 0);
        step(1);
        chk("held_req", req, 4'b0001);
        chk("held_lamp", call_lamp, 4'b0001);
        btn[0] = 1'b0;
        step(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
